// File: rtl/i2c_master_pkg.sv
// rtl/i2c_master_pkg.sv - shared types and constants for the I2C master controller
package i2c_master_pkg;

  // Transaction sequencer states, in bus order
  typedef enum logic [3:0] {
    IDLE,
    START,
    DEV,
    ACK1,
    MADDR,
    ACK2,
    DATA,
    ACK3,
    STOP,
    DONE
  } state_t;

  // Quarter phases of one SCL bit period
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } qphase_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_bit_timer.sv
// rtl/i2c_bit_timer.sv - quarter-phase timer for one SCL bit (scl_i port only with I2C_CLK_STRETCH_EN)
module i2c_bit_timer
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    run,
`ifdef I2C_CLK_STRETCH_EN
  input  logic    scl_i,
`endif
  output qphase_t phase,
  output logic    phase_last,
  output logic    bit_done
);

  localparam int QW = $clog2(CLK_DIV + 1);

  logic [QW-1:0] qcnt;
  logic          hold;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low during the high phase freezes the counter
  assign hold = (phase == Q2) && !scl_i;
`else
  assign hold = 1'b0;
`endif

  assign phase_last = (qcnt == QW'(CLK_DIV - 1)) && !hold;
  assign bit_done   = phase_last && (phase == Q3);

  // Quarter counter and phase sequence; parked at Q0 while not running
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      qcnt  <= '0;
      phase <= Q0;
    end else if (!hold) begin
      if (phase_last) begin
        qcnt  <= '0;
        phase <= qphase_t'(phase + 2'd1);
      end else begin
        qcnt <= qcnt + QW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-transaction I2C master; optional I2C_CLK_STRETCH_EN honours SCL stretching
module i2c_master_ctrl
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_mem_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_o,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i
);

  state_t     state;
  qphase_t    phase;
  logic       phase_last;
  logic       bit_done;
  logic       timer_run;
  logic       scl_rise;
  logic       sample;
  logic       rw_q;
  logic [7:0] maddr_q;
  logic [7:0] wdata_q;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       nack_flag;

  assign timer_run = (state != IDLE) && (state != DONE);
  assign scl_rise  = (phase == Q1) && phase_last;
  assign sample    = (phase == Q2) && phase_last;

`ifndef I2C_CLK_STRETCH_EN
  logic scl_unused;
  assign scl_unused = scl_i;
`endif

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .run        (timer_run),
`ifdef I2C_CLK_STRETCH_EN
    .scl_i      (scl_i),
`endif
    .phase      (phase),
    .phase_last (phase_last),
    .bit_done   (bit_done)
  );

  // Transaction sequencer; pin levels are registered on the edge that enters each phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      scl_o     <= 1'b1;
      sda_oe    <= 1'b0;
      rw_q      <= 1'b0;
      maddr_q   <= 8'h00;
      wdata_q   <= 8'h00;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      nack_flag <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rw_q      <= cmd_rw;
            maddr_q   <= cmd_mem_addr;
            wdata_q   <= cmd_wdata;
            shreg     <= {cmd_dev_addr, cmd_rw};
            bit_cnt   <= 3'd0;
            nack_flag <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          // SDA falls in the middle of the SCL-high period
          if (scl_rise) sda_oe <= 1'b1;
          if (bit_done) begin
            scl_o  <= 1'b0;
            sda_oe <= ~shreg[7];
            state  <= DEV;
          end
        end
        DEV, MADDR, DATA: begin
          if (scl_rise) scl_o <= 1'b1;
          if (sample && (state == DATA) && (rw_q == RW_READ)) shreg <= {shreg[6:0], sda_i};
          if (bit_done) begin
            scl_o   <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= (state == DEV) ? ACK1 : (state == MADDR) ? ACK2 : ACK3;
            end else if (!((state == DATA) && (rw_q == RW_READ))) begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
        end
        ACK1, ACK2, ACK3: begin
          if (scl_rise) scl_o <= 1'b1;
          // ACK3 on a read is the master's own NACK, so it is not checked
          if (sample && sda_i && !((state == ACK3) && (rw_q == RW_READ))) nack_flag <= 1'b1;
          if (bit_done) begin
            scl_o <= 1'b0;
            if (nack_flag || (state == ACK3)) begin
              sda_oe <= 1'b1;
              state  <= STOP;
            end else if (state == ACK1) begin
              shreg  <= maddr_q;
              sda_oe <= ~maddr_q[7];
              state  <= MADDR;
            end else begin
              shreg  <= wdata_q;
              sda_oe <= (rw_q == RW_WRITE) & ~wdata_q[7];
              state  <= DATA;
            end
          end
        end
        STOP: begin
          if (scl_rise) scl_o <= 1'b1;
          // SDA rises while SCL is high for the STOP condition
          if (sample) sda_oe <= 1'b0;
          if (bit_done) begin
            rsp_valid <= 1'b1;
            rsp_nack  <= nack_flag;
            if ((rw_q == RW_READ) && !nack_flag) rsp_rdata <= shreg;
            state <= DONE;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - scoreboard bench for i2c_master_ctrl with a behavioural I2C slave
module tb_i2c_master_ctrl;

  localparam int         CLK_DIV   = 2;
  localparam logic [6:0] SLAVE_ID  = 7'd1;
  // Latency counts edges from the accepting edge through the edge raising rsp_valid
  localparam int         LAT_FULL  = 116 * CLK_DIV + 1;
  localparam int         LAT_NACK1 = 44 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev_addr = 7'd0;
  logic [7:0] cmd_mem_addr = 8'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_o;
  logic       scl_i;
  logic       sda_oe;
  logic       sda_i;
  logic       stretch = 1'b0;
  logic       slave_drive = 1'b0;

  assign sda_i = !(sda_oe || slave_drive);
  assign scl_i = scl_o & ~stretch;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_mem_addr (cmd_mem_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_nack     (rsp_nack),
    .busy         (busy),
    .scl_o        (scl_o),
    .scl_i        (scl_i),
    .sda_oe       (sda_oe),
    .sda_i        (sda_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    logic       nack;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  logic [7:0] mem [0:255];
  logic [7:0] obs[$];
  int         stop_cnt = 0;
  logic       master_ack3 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the oldest expectation whenever a response appears
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_nack", 32'(rsp_nack), 32'(e.nack));
          chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  // Behavioural slave: samples the bus once per clk and follows START/bits/ACK/STOP
  initial begin
    logic       prev_scl, prev_sda, scl_s, sda_s, active, rw_s;
    logic [7:0] sh, maddr_s;
    int         bit_idx, byte_idx;
    prev_scl = 1'b1; prev_sda = 1'b1; active = 1'b0; rw_s = 1'b0;
    sh = 8'h00; maddr_s = 8'h00; bit_idx = 0; byte_idx = 0;
    forever begin
      @(negedge clk);
      scl_s = scl_o;
      sda_s = sda_i;
      if (prev_scl && scl_s && prev_sda && !sda_s) begin
        active = 1'b1; byte_idx = 0; bit_idx = 0; slave_drive = 1'b0;
      end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
        active = 1'b0; slave_drive = 1'b0; stop_cnt++;
      end else if (active) begin
        if (!prev_scl && scl_s) begin
          if (bit_idx < 8) begin
            sh = {sh[6:0], sda_s};
            bit_idx++;
          end else if (bit_idx == 8) begin
            if (byte_idx == 2 && rw_s) master_ack3 = sda_s;
            bit_idx = 9;
          end
        end else if (prev_scl && !scl_s) begin
          if (bit_idx == 8) begin
            if (!(byte_idx == 2 && rw_s)) obs.push_back(sh);
            case (byte_idx)
              0: begin
                rw_s = sh[0];
                if (sh[7:1] == SLAVE_ID) slave_drive = 1'b1;
                else begin active = 1'b0; slave_drive = 1'b0; end
              end
              1: begin maddr_s = sh; slave_drive = 1'b1; end
              default: begin
                if (!rw_s) begin mem[maddr_s] = sh; slave_drive = 1'b1; end
                else slave_drive = 1'b0;
              end
            endcase
          end else if (bit_idx == 9) begin
            slave_drive = 1'b0; bit_idx = 0; byte_idx++;
            if (byte_idx == 2 && rw_s) slave_drive = !mem[maddr_s][7];
          end else if (byte_idx == 2 && rw_s && bit_idx >= 1 && bit_idx <= 7) begin
            slave_drive = !mem[maddr_s][7 - bit_idx];
          end
        end
      end
      prev_scl = scl_s;
      prev_sda = sda_s;
    end
  end

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] ma, input logic [7:0] wd,
                       input bit expect_rsp, input logic [7:0] er, input logic en, input int elat);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 1000) begin @(negedge clk); guard++; end
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_mem_addr = ma; cmd_wdata = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (expect_rsp) exp_q.push_back('{rdata: er, nack: en, lat: elat, acc: cyc});
  endtask

  task automatic wait_rsp();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
    chk("rsp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] want [3];
    want[0] = b0; want[1] = b1; want[2] = b2;
    chk("bus_byte_count", 32'(obs.size()), 32'(n));
    for (int i = 0; i < n && i < obs.size(); i++) chk("bus_byte", 32'(obs[i]), 32'(want[i]));
  endtask

  initial begin
    int   s0;
    logic p;
    int   g;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h05;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_rsp_nack", 32'(rsp_nack), 32'd0);
    chk("reset_scl_o", 32'(scl_o), 32'd1);
    chk("reset_sda_oe", 32'(sda_oe), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    obs.delete(); s0 = stop_cnt;
    issue(1'b0, SLAVE_ID, 8'h02, 8'h7F, 1'b1, 8'h00, 1'b0, LAT_FULL);
    wait_rsp();
    chk_bytes(3, 8'h02, 8'h02, 8'h7F);
    chk("write_mem2", 32'(mem[2]), 32'h7F);
    chk("write_stop", 32'(stop_cnt - s0), 32'd1);

    obs.delete(); s0 = stop_cnt; master_ack3 = 1'b0;
    issue(1'b1, SLAVE_ID, 8'h01, 8'h00, 1'b1, 8'h05, 1'b0, LAT_FULL);
    wait_rsp();
    chk_bytes(2, 8'h03, 8'h01, 8'h00);
    chk("read_master_nack", 32'(master_ack3), 32'd1);
    chk("read_stop", 32'(stop_cnt - s0), 32'd1);

    issue(1'b1, SLAVE_ID, 8'h02, 8'h00, 1'b1, 8'h7F, 1'b0, LAT_FULL);
    wait_rsp();

    obs.delete(); s0 = stop_cnt;
    issue(1'b0, 7'd3, 8'h04, 8'hAA, 1'b1, 8'h7F, 1'b1, LAT_NACK1);
    wait_rsp();
    chk_bytes(1, 8'h06, 8'h00, 8'h00);
    chk("nack_mem4", 32'(mem[4]), 32'h00);
    chk("nack_stop", 32'(stop_cnt - s0), 32'd1);

    s0 = stop_cnt;
    issue(1'b0, SLAVE_ID, 8'h05, 8'h33, 1'b0, 8'h00, 1'b0, 0);
    repeat (96) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_scl_o", 32'(scl_o), 32'd1);
    chk("midreset_sda_oe", 32'(sda_oe), 32'd0);
    chk("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset_no_stop", 32'(stop_cnt - s0), 32'd0);
    chk("midreset_mem5", 32'(mem[5]), 32'h00);

    obs.delete();
    issue(1'b0, SLAVE_ID, 8'h06, 8'hC3, 1'b1, 8'h00, 1'b0, LAT_FULL);
    wait_rsp();
    chk_bytes(3, 8'h02, 8'h06, 8'hC3);
    chk("post_reset_mem6", 32'(mem[6]), 32'hC3);

    issue(1'b1, SLAVE_ID, 8'h06, 8'h00, 1'b1, 8'hC3, 1'b0, LAT_FULL);
    wait_rsp();

`ifdef I2C_CLK_STRETCH_EN
    issue(1'b1, SLAVE_ID, 8'h01, 8'h00, 1'b1, 8'h05, 1'b0, LAT_FULL + 10);
    repeat (20) @(negedge clk);
    g = 0;
    p = scl_o;
    @(negedge clk);
    while (!(!p && scl_o) && g < 200) begin p = scl_o; @(negedge clk); g++; end
    stretch = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    stretch = 1'b0;
    wait_rsp();
`else
    p = 1'b0;
    g = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
